// File: rtl/edge_relaxer.sv
// Dijkstra edge relaxer: scans every neighbour v of the settled node u and emits a
// write-back strobe when dist[u]+w(u,v) improves dist[v]. Optional macro: RELAX_PREDECESSOR_EN.
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif

module edge_relaxer #(
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] current_node,
  input  logic [VALUE_WIDTH-1:0] current_dist,
  output logic                   query_enable,
  output logic [INDEX_WIDTH-1:0] from_node,
  output logic [INDEX_WIDTH-1:0] to_node,
  input  logic                   edge_ready,
  input  logic [VALUE_WIDTH-1:0] edge_value,
  output logic [INDEX_WIDTH-1:0] dist_index,
  input  logic [VALUE_WIDTH-1:0] dist_value,
  input  logic                   visited,
  output logic                   update_valid,
  output logic [INDEX_WIDTH-1:0] update_index,
  output logic [VALUE_WIDTH-1:0] update_dist,
`ifdef RELAX_PREDECESSOR_EN
  output logic [INDEX_WIDTH-1:0] update_pred,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    EVAL   = 3'd3,
    WRITE  = 3'd4,
    NEXT   = 3'd5,
    FINISH = 3'd6
  } state_t;

  localparam logic [VALUE_WIDTH-1:0] INF = '1;
  localparam logic [INDEX_WIDTH-1:0] ONE = 1;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] u_q, n_q, v_q;
  logic [VALUE_WIDTH-1:0] du_q, w_q;
  logic [VALUE_WIDTH:0]   sum_wide;
  logic [VALUE_WIDTH-1:0] sum_sat;
  logic                   relax;
  logic                   last_node;

  // Infinity is absorbing, and any carry out of the add also clamps to infinity.
  always_comb begin
    sum_wide = {1'b0, du_q} + {1'b0, w_q};
    if (du_q == INF || sum_wide[VALUE_WIDTH]) sum_sat = INF;
    else                                      sum_sat = sum_wide[VALUE_WIDTH-1:0];
  end

  assign relax     = (w_q != '0) && !visited && (v_q != u_q) && (sum_sat < dist_value);
  assign last_node = (v_q == n_q - ONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      u_q     <= '0;
      n_q     <= '0;
      v_q     <= '0;
      du_q    <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          u_q  <= current_node;
          du_q <= current_dist;
          n_q  <= number_of_nodes;
          v_q  <= '0;
        end
        WAIT: if (edge_ready) w_q <= edge_value;
        NEXT: if (!last_node) v_q <= v_q + ONE;
        default: ;
      endcase
    end
  end

  // Cache handshake: query_enable is held with from_node/to_node stable until
  // edge_ready is sampled high in WAIT; edge_ready is ignored in every other state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (number_of_nodes == '0) ? FINISH : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (edge_ready) state_d = EVAL;
      EVAL:    state_d = relax ? WRITE : NEXT;
      WRITE:   state_d = NEXT;
      NEXT:    state_d = last_node ? FINISH : ISSUE;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign query_enable = (state_q == ISSUE) || (state_q == WAIT);
  assign from_node    = u_q;
  assign to_node      = v_q;
  assign dist_index   = v_q;
  assign update_valid = (state_q == WRITE);
  assign update_index = update_valid ? v_q : '0;
  assign update_dist  = update_valid ? sum_sat : '0;
`ifdef RELAX_PREDECESSOR_EN
  assign update_pred  = update_valid ? u_q : '0;
`endif
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FINISH);
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_edge_relaxer.sv
// Randomized bench for edge_relaxer: cache and distance-store models, expected-update
// scoreboard computed from the relaxation rule, latency and handshake checks.
module tb_edge_relaxer;
  localparam int IW = 4;
  localparam int VW = 16;
  localparam int NMAX = 1 << IW;
  localparam logic [VW-1:0] MAXV = 16'hFFFF;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [IW-1:0] number_of_nodes = '0, current_node = '0;
  logic [VW-1:0] current_dist = '0;
  logic          start = 1'b0;
  logic          query_enable;
  logic [IW-1:0] from_node, to_node, dist_index;
  logic          edge_ready = 1'b0;
  logic [VW-1:0] edge_value = '0;
  logic [VW-1:0] dist_value;
  logic          visited;
  logic          update_valid;
  logic [IW-1:0] update_index;
  logic [VW-1:0] update_dist;
`ifdef RELAX_PREDECESSOR_EN
  logic [IW-1:0] update_pred;
`endif
  logic          busy, done;
  logic [2:0]    fsm_state;

  edge_relaxer #(.INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) dut (
    .clock(clock), .reset(reset), .number_of_nodes(number_of_nodes), .start(start),
    .current_node(current_node), .current_dist(current_dist),
    .query_enable(query_enable), .from_node(from_node), .to_node(to_node),
    .edge_ready(edge_ready), .edge_value(edge_value),
    .dist_index(dist_index), .dist_value(dist_value), .visited(visited),
    .update_valid(update_valid), .update_index(update_index), .update_dist(update_dist),
`ifdef RELAX_PREDECESSOR_EN
    .update_pred(update_pred),
`endif
    .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // bench-owned graph row for u and distance store
  logic [VW-1:0] wrow[NMAX];
  logic [VW-1:0] dist_mem[NMAX];
  logic          vis_mem[NMAX];
  assign dist_value = dist_mem[dist_index];
  assign visited    = vis_mem[dist_index];

  int checks = 0, failures = 0;
  logic [IW+VW-1:0] exp_q[$];
  int stall_cycles = 0, q_age = 0, qidx = 0, cur_u = 0, done_cnt = 0;
  bit abort = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // edge cache: answers stall_cycles+1 cycles after the request first appears
  initial forever begin
    @(negedge clock);
    if (!query_enable) begin
      if (q_age > 0 && !abort) check("query_len", q_age, stall_cycles + 2);
      q_age = 0;
      edge_ready = 1'b0;
      edge_value = VW'($urandom);
    end else begin
      if (q_age == 0) qidx++;
      q_age++;
      check("query_to_node", {28'd0, to_node}, qidx - 1);
      check("query_from_node", {28'd0, from_node}, cur_u);
      if (q_age > stall_cycles + 1) begin
        edge_ready = 1'b1;
        edge_value = wrow[to_node];
      end
    end
  end

  // scoreboard monitor: every write strobe must match the next expected update
  initial forever begin
    @(negedge clock);
    if (update_valid) begin
      if (exp_q.size() == 0) check("update_unexpected", {31'd0, update_valid}, 0);
      else check("update", {12'd0, update_index, update_dist}, {12'd0, exp_q.pop_front()});
`ifdef RELAX_PREDECESSOR_EN
      check("update_pred", {28'd0, update_pred}, cur_u);
`endif
      dist_mem[update_index] = update_dist;
    end
    if (done) begin
      done_cnt++;
      check("done_busy", {31'd0, busy}, 1);
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < NMAX; i++) begin
      wrow[i] = '0; dist_mem[i] = MAXV; vis_mem[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // reference: relaxation rule over the row, in plain integer arithmetic
  function automatic int build_expected(input int n, input int u, input int du);
    longint s;
    int r = 0;
    exp_q.delete();
    for (int v = 0; v < n; v++) begin
      if (wrow[v] != 0 && !vis_mem[v] && v != u) begin
        s = (du == int'(MAXV)) ? longint'(MAXV) : longint'(du) + longint'(wrow[v]);
        if (s > longint'(MAXV)) s = longint'(MAXV);
        if (s < longint'(dist_mem[v])) begin
          exp_q.push_back({IW'(v), VW'(s)});
          r++;
        end
      end
    end
    return r;
  endfunction

  // driver: one full scan, with optional stray start pulse mid-scan
  task automatic run_scan(input int n, input int u, input int du, input int stall, input bit poke);
    int r, cycles;
    r = build_expected(n, u, du);
    stall_cycles = stall; qidx = 0; cur_u = u; done_cnt = 0;
    @(negedge clock);
    number_of_nodes = IW'(n); current_node = IW'(u); current_dist = VW'(du); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < 3000) begin
      if (poke && cycles == 3) begin
        start = 1'b1; current_node = ~IW'(u); current_dist = '0; number_of_nodes = '1;
      end
      if (poke && cycles == 4) start = 1'b0;
      @(negedge clock);
      cycles++;
    end
    check("latency", cycles, 4 * n + r + 1 + n * stall);
    @(negedge clock);
    check("done_pulses", done_cnt, 1);
    check("done_low", {31'd0, done}, 0);
    check("busy_low", {31'd0, busy}, 0);
    check("updates_left", exp_q.size(), 0);
    if (cycles >= 3000) do_reset();
  endtask

  int n, u, du, waited;

  initial begin
    clear_mem();
    do_reset();
    reset = 1'b1;
    @(negedge clock);
    check("rst_query_enable", {31'd0, query_enable}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_update_valid", {31'd0, update_valid}, 0);
    check("rst_nodes", {24'd0, from_node, to_node}, 0);
    check("rst_update", {12'd0, update_index, update_dist}, 0);
    reset = 1'b0;

    // basic relax
    clear_mem();
    wrow[0] = 16'd3; wrow[1] = 16'd5; wrow[2] = 16'd7; wrow[3] = 16'd0;
    run_scan(4, 0, 0, 0, 0);

    // no improvement then improvement
    clear_mem(); wrow[1] = 16'd5; dist_mem[1] = 16'd15;
    run_scan(2, 0, 10, 0, 0);
    clear_mem(); wrow[1] = 16'd5; dist_mem[1] = 16'd16;
    run_scan(2, 0, 10, 0, 0);

    // visited skip
    clear_mem(); wrow[2] = 16'd1; vis_mem[2] = 1'b1; wrow[3] = 16'd2;
    run_scan(4, 1, 0, 0, 0);

    // saturation, and infinite dist_u
    clear_mem(); wrow[1] = 16'h0020;
    run_scan(2, 0, 16'hFFF0, 0, 0);
    clear_mem(); wrow[1] = 16'h0001;
    run_scan(2, 0, 16'hFFFF, 0, 0);

    // cache stall plus a start pulse that must be ignored
    clear_mem(); wrow[0] = 16'd4; wrow[1] = 16'd9; dist_mem[1] = 16'd3;
    run_scan(3, 2, 1, 6, 1);

    // empty graph
    clear_mem();
    run_scan(0, 0, 0, 0, 0);

    // reset mid-scan while waiting on the cache at v=2
    clear_mem(); wrow[1] = 16'd3; wrow[2] = 16'd3; wrow[3] = 16'd3;
    void'(build_expected(4, 0, 0));
    stall_cycles = 3; qidx = 0; cur_u = 0; done_cnt = 0;
    @(negedge clock);
    number_of_nodes = 4'd4; current_node = 4'd0; current_dist = '0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waited = 0;
    while (!(query_enable && to_node == 4'd2) && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    check("reach_wait_v2", {31'd0, waited < 200}, 1);
    @(negedge clock);
    abort = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_query_enable", {31'd0, query_enable}, 0);
    check("abort_to_node", {28'd0, to_node}, 0);
    check("abort_updates_done", exp_q.size(), 2);
    repeat (10) begin
      @(negedge clock);
      check("abort_quiet", {30'd0, done, update_valid}, 0);
    end
    abort = 1'b0;
    clear_mem(); wrow[3] = 16'd8;
    run_scan(4, 0, 2, 0, 0);

    // randomized scans
    for (int it = 0; it < 30; it++) begin
      clear_mem();
      for (int i = 0; i < NMAX; i++) begin
        wrow[i]     = ($urandom_range(0, 9) < 3) ? 16'd0 :
                      (($urandom_range(0, 9) == 0) ? VW'($urandom) : VW'($urandom_range(1, 300)));
        dist_mem[i] = ($urandom_range(0, 9) < 3) ? MAXV : VW'($urandom_range(0, 600));
        vis_mem[i]  = ($urandom_range(0, 4) == 0);
      end
      n  = $urandom_range(0, NMAX - 1);
      u  = $urandom_range(0, NMAX - 1);
      du = ($urandom_range(0, 7) == 0) ? int'(16'hFFF0) : $urandom_range(0, 300);
      run_scan(n, u, du, $urandom_range(0, 2), (n >= 1) && ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/edge_relaxer.md
Name: edge_relaxer

Overview:
- Downstream consumer of the edge cache in the Dijkstra datapath.
- Given the current settled node u and its distance, it scans every to_node v in 0..number_of_nodes-1. For each v it queries the edge cache for w(u,v) and reads dist[v] and visited[v] from the distance store.
- It emits a write-back strobe whenever dist[u]+w(u,v) < dist[v].
- The top-level controller starts it once per extracted node and waits for done.

Parameters:
- INDEX_WIDTH, `DEFAULT_INDEX_WIDTH, width of node indices and of number_of_nodes.
- VALUE_WIDTH, `DEFAULT_VALUE_WIDTH, width of edge weights and distances; all-ones means infinity.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- number_of_nodes  input  INDEX_WIDTH  node count N; sampled on start.
- start  input  1  one-cycle pulse, accepted only in IDLE.
- current_node  input  INDEX_WIDTH  u; sampled on start.
- current_dist  input  VALUE_WIDTH  dist[u]; sampled on start.
- query_enable  output  1  to edge cache.
- from_node  output  INDEX_WIDTH  to edge cache; equals latched u.
- to_node  output  INDEX_WIDTH  to edge cache; equals scan index v.
- edge_ready  input  1  edge cache ready.
- edge_value  input  VALUE_WIDTH  edge cache data; 0 means no edge.
- dist_index  output  INDEX_WIDTH  combinational read address into the distance store; equals v.
- dist_value  input  VALUE_WIDTH  dist[dist_index], combinational.
- visited  input  1  visited[dist_index], combinational.
- update_valid  output  1  one-cycle write strobe.
- update_index  output  INDEX_WIDTH  v being relaxed.
- update_dist  output  VALUE_WIDTH  new distance.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the scan completes.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Latched u, dist_u and v are 0.
- IDLE:
  - On start, latch current_node, current_dist and number_of_nodes, set v=0.
  - If N==0, go to FINISH; otherwise go to ISSUE.
  - start seen outside IDLE is ignored.
- ISSUE:
  - Drive query_enable=1, go to WAIT.
- WAIT:
  - Hold query_enable=1 with from_node/to_node stable until edge_ready is sampled 1.
  - In that cycle, register edge_value into w, deassert query_enable, go to EVAL.
  - No timeout.
- EVAL (one cycle):
  - sum = dist_u + w, computed in VALUE_WIDTH+1 bits and saturated to all-ones on carry.
  - If dist_u is all-ones, sum is all-ones.
  - relax = (w!=0) && !visited && (v!=u) && (sum < dist_value), strict less-than.
  - If relax, go to WRITE; otherwise go to NEXT.
- WRITE (one cycle):
  - update_valid=1, update_index=v, update_dist=sum.
  - The distance store commits on this posedge.
  - Then go to NEXT.
- NEXT:
  - If v==N-1, go to FINISH.
  - Otherwise v=v+1 and go to ISSUE.
  - v never wraps past N-1.
- FINISH:
  - done=1 for exactly one cycle, then go to IDLE.
  - busy drops in the same cycle done falls.
- Latency with a cache returning ready in the cycle after query:
  - Per node: ISSUE 1, WAIT 1, EVAL 1, NEXT 1, plus WRITE 1 if relaxed.
  - Start to done = 4N + relaxations + 1 cycles.
- query_enable is low for at least one cycle between successive queries, so the cache sees a fresh request.
- update_valid is never asserted for the same v twice in one scan.
- Reset mid-scan:
  - Go to IDLE immediately; all outputs are 0 on the next cycle.
  - No update_valid or done is emitted for the aborted scan.

Optional Feature:
- Macro RELAX_PREDECESSOR_EN.
- Defined:
  - Adds output update_pred (INDEX_WIDTH), driven with latched u whenever update_valid=1 and 0 otherwise.
  - Used to build the shortest-path tree.
- Undefined:
  - Port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic relax:
  - Stimulus: N=4, u=0, dist_u=0, edges w(0,1..3)=5,7,0; dist[1..3]=all-ones; none visited.
  - Response: updates (1,5) and (2,7) only.
  - Response: no update for v=0 (self) or v=3 (no edge); one done pulse.
- No improvement:
  - Stimulus: dist_u=10, w=5, dist[v]=15.
  - Response: no update, because 15 is not < 15.
  - Stimulus: dist[v]=16.
  - Response: update to 15.
- Visited skip:
  - Stimulus: visited[2]=1 with w(u,2)=1, dist[2]=all-ones.
  - Response: no update for index 2.
- Saturation:
  - Stimulus: VALUE_WIDTH=16, dist_u=0xFFF0, w=0x0020, dist[v]=0xFFFF.
  - Response: sum saturates to 0xFFFF; no update.
- Cache stall:
  - Stimulus: the bench holds edge_ready low for 6 cycles.
  - Response: query_enable and to_node stay stable throughout; the scan completes with the correct update.
- Reset mid-scan:
  - Stimulus: assert reset while in WAIT at v=2.
  - Response: next cycle busy=0, query_enable=0, no done pulse.
  - Response: a fresh start then completes normally.
